regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with a per-register pending scoreboard. It is the next-generation architectural register file for the RISC-V core, sized for multi-issue datapaths. It provides NUM_READ combinational read ports and NUM_WRITE prioritised synchronous write ports, with an optional hardwired zero register. A pending-bit scoreboard lets the issue stage stall reads of registers whose producer has not yet written back.

## Interface
- WIDTH, 32: data width in bits.
- DEPTH, 32: number of registers; AW = $clog2(DEPTH) (localparam).
- NUM_READ, 2: read ports (1..8).
- NUM_WRITE, 1: write ports (1..4).
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, is never pending.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- ra  in  NUM_READ*AW  read addresses; port i at ra[i*AW +: AW].
- rd  out  NUM_READ*WIDTH  read data; port i at rd[i*WIDTH +: WIDTH].
- busy  out  NUM_READ  busy[i] = 1 when register ra[i] is pending.
- wen  in  NUM_WRITE  per-port write enable.
- wa  in  NUM_WRITE*AW  write addresses.
- wd  in  NUM_WRITE*WIDTH  write data.
- set_en  in  1  mark register set_addr pending (producer issued).
- set_addr  in  AW  register to mark pending.

## Operation
- Storage: DEPTH x WIDTH array plus DEPTH-bit pending vector.
- Read: rd[i] = array[ra[i]], combinational. Returns 0 when ZERO_REG=1 and ra[i]==0. An address >= DEPTH returns 0 with busy[i]=0.
- Write: on each rising edge, every port j with wen[j]=1 writes wd[j] to array[wa[j]]. The write is dropped when ZERO_REG=1 and wa[j]==0, or when wa[j] >= DEPTH.
- Write conflict: if several ports target the same address in one cycle, the highest-index port wins.
- Scoreboard: a valid write to address a clears pending[a]. set_en=1 sets pending[set_addr].
- Same cycle, same address, set and clear: set wins, so pending stays 1. This represents a new producer issued as the old one retires.
- ZERO_REG=1: set_en with set_addr==0 is ignored.
- busy[i] = pending[ra[i]], masked as described under Configuration.

## Timing
- Reset (rst=1, async): all registers are 0 and all pending bits are 0 immediately. Consequently rd=0 and busy=0 for all ports.
- While rst=1, writes and set_en are ignored. The first update is on the first rising edge after rst deasserts.
- Reset asserted mid-operation discards any write or set landing on that edge.
- Read latency: 0 cycles (combinational).
- Write-to-read latency: 1 cycle; see REGFILE_BYPASS_EN for 0 cycles.
- Set-to-busy latency: 1 cycle. busy rises after the edge on which set_en was sampled.
- Clear-to-busy latency:
  - 1 cycle without bypass.
  - 0 cycles with bypass: busy[i] drops in the same cycle the matching write is presented.

## Configuration
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding.
  - When any wen[j]=1 with wa[j]==ra[i] (a valid, non-zero-register write), rd[i] = wd[j] in the same cycle, using the same highest-index-wins priority.
  - busy[i] is forced to 0 for that port, unless set_en targets the same address in that cycle. This matches the set-wins rule.
- Undefined: no forwarding. rd and busy reflect stored state only, and the array is written on the edge.

## Test plan
1. Reset: write 0xDEADBEEF to x5, then pulse rst asynchronously between edges.
   - Required: rd for ra=5 reads 0 immediately.
   - Required: busy=0 on all ports.
2. Zero register (ZERO_REG=1): wen=1, wa=0, wd=0xFFFFFFFF; then set_en=1, set_addr=0.
   - Required: ra=0 reads 0.
   - Required: busy=0.
3. Write port conflict (NUM_WRITE=2): both ports write x7, port0 wd=0x11, port1 wd=0x22.
   - Required: ra=7 reads 0x22 the next cycle.
4. Bypass:
   - Stimulus: x3 holds 0x5; wen=1, wa=3, wd=0xA; ra=3.
   - With REGFILE_BYPASS_EN: rd=0xA in the same cycle.
   - Without it: rd=0x5 in the same cycle, then 0xA after the edge.
5. Scoreboard:
   - Stimulus: set_en x9 at edge N.
   - Required: busy=1 from N until the write to x9 at edge M.
   - Required: busy=0 after M, or during cycle M with bypass.
6. Set/clear collision: same cycle, set_en x4 and wen x4 wd=0x77.
   - Required: rd(ra=4)=0x77 next cycle.
   - Required: busy stays 1.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register pending scoreboard.
// Ports: clk, rst (async, active-high), ra/rd/busy read side,
//   wen/wa/wd write side, set_en/set_addr scoreboard set.
//   Optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter  int WIDTH     = 32,
  parameter  int DEPTH     = 32,
  parameter  int NUM_READ  = 2,
  parameter  int NUM_WRITE = 1,
  parameter  int ZERO_REG  = 1,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_READ*AW-1:0]    ra,
  output logic [NUM_READ*WIDTH-1:0] rd,
  output logic [NUM_READ-1:0]       busy,
  input  logic [NUM_WRITE-1:0]      wen,
  input  logic [NUM_WRITE*AW-1:0]   wa,
  input  logic [NUM_WRITE*WIDTH-1:0] wd,
  input  logic                      set_en,
  input  logic [AW-1:0]             set_addr
);

  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  // Address is real storage and not the hardwired zero register.
  function automatic logic f_ok(
    input logic [AW-1:0] a
  );
    f_ok = ({1'b0, a} < LIM)
         && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [NUM_WRITE-1:0]   w_wok;
  logic                   w_sok;
  logic [DEPTH*WIDTH-1:0] w_memf;
  logic [DEPTH-1:0]       w_pend;

  always_comb begin
    w_wok = '0;
    for (int j = 0; j < NUM_WRITE; j++)
      w_wok[j] = wen[j] && f_ok(wa[j*AW +: AW]);
  end

  assign w_sok = set_en && f_ok(set_addr);

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_reg
      logic             r_q;
      logic [WIDTH-1:0] r_d;
      logic             w_we;
      logic             w_set;
      logic [WIDTH-1:0] w_nd;

      // Ascending scan: the highest-index matching port wins.
      always_comb begin
        w_we = 1'b0;
        w_nd = r_d;
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (w_wok[j] &&
              wa[j*AW +: AW] == AW'(k)) begin
            w_we = 1'b1;
            w_nd = wd[j*WIDTH +: WIDTH];
          end
        end
      end

      assign w_set = w_sok && (set_addr == AW'(k));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_d <= '0;
          r_q <= 1'b0;
        end else begin
          if (w_we)
            r_d <= w_nd;
          // A new producer issuing as the old retires keeps it pending.
          if (w_set)
            r_q <= 1'b1;
          else if (w_we)
            r_q <= 1'b0;
        end
      end

      assign w_memf[k*WIDTH +: WIDTH] = r_d;
      assign w_pend[k]                = r_q;
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < NUM_READ; i++) begin : g_rd
      logic [AW-1:0]    w_a;
      logic [WIDTH-1:0] w_v;
      logic             w_b;
`ifdef REGFILE_BYPASS_EN
      logic             w_hit;
      logic             w_sh;
`endif

      assign w_a = ra[i*AW +: AW];

      always_comb begin
        w_v = '0;
        w_b = 1'b0;
        for (int m = 0; m < DEPTH; m++) begin
          if (w_a == AW'(m)) begin
            w_v = w_memf[m*WIDTH +: WIDTH];
            w_b = w_pend[m];
          end
        end
`ifdef REGFILE_BYPASS_EN
        w_hit = 1'b0;
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (w_wok[j] &&
              wa[j*AW +: AW] == w_a) begin
            w_hit = 1'b1;
            w_v   = wd[j*WIDTH +: WIDTH];
          end
        end
        w_sh = w_sok && (set_addr == w_a);
        if (w_hit && !w_sh)
          w_b = 1'b0;
`endif
        if (!f_ok(w_a)) begin
          w_v = '0;
          w_b = 1'b0;
        end
      end

      assign rd[i*WIDTH +: WIDTH] = w_v;
      assign busy[i]              = w_b;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp.
// Directed plan items followed by a randomized phase against a model.
module tb_regfile_mp;

  localparam int W  = 32;
  localparam int D  = 24;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR*AW-1:0]  ra;
  logic [NR*W-1:0]   rd;
  logic [NR-1:0]     busy;
  logic [NW-1:0]     wen;
  logic [NW*AW-1:0]  wa;
  logic [NW*W-1:0]   wd;
  logic              set_en;
  logic [AW-1:0]     set_addr;

  int n_chk = 0;
  int n_err = 0;

  regfile_mp #(
    .WIDTH(W), .DEPTH(D), .NUM_READ(NR),
    .NUM_WRITE(NW), .ZERO_REG(1)
  ) dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd),
    .busy(busy), .wen(wen), .wa(wa), .wd(wd),
    .set_en(set_en), .set_addr(set_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          is_busy;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  // Reference model of architectural state.
  logic [W-1:0] m_mem [32];
  logic [31:0]  m_pend;

  function automatic bit mok(input logic [AW-1:0] a);
    return (a < AW'(D)) && (a != '0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 32; k++) m_mem[k] <= '0;
      m_pend <= '0;
    end else begin
      for (int j = 0; j < NW; j++) begin
        if (wen[j] && mok(wa[j*AW +: AW])) begin
          m_mem[wa[j*AW +: AW]]  <= wd[j*W +: W];
          m_pend[wa[j*AW +: AW]] <= 1'b0;
        end
      end
      if (set_en && mok(set_addr))
        m_pend[set_addr] <= 1'b1;
    end
  end

  function automatic logic [31:0] model_rd(input int p);
    logic [AW-1:0] a;
    logic [31:0]   v;
    a = ra[p*AW +: AW];
    if (!mok(a)) return '0;
    v = m_mem[a];
`ifdef REGFILE_BYPASS_EN
    for (int j = 0; j < NW; j++)
      if (wen[j] && mok(wa[j*AW +: AW]) && wa[j*AW +: AW] == a)
        v = wd[j*W +: W];
`endif
    return v;
  endfunction

  function automatic logic [31:0] model_busy(input int p);
    logic [AW-1:0] a;
    logic          b;
    a = ra[p*AW +: AW];
    if (!mok(a)) return '0;
    b = m_pend[a];
`ifdef REGFILE_BYPASS_EN
    begin
      bit hit;
      hit = 1'b0;
      for (int j = 0; j < NW; j++)
        if (wen[j] && mok(wa[j*AW +: AW]) && wa[j*AW +: AW] == a)
          hit = 1'b1;
      if (hit && !(set_en && mok(set_addr) && set_addr == a))
        b = 1'b0;
    end
`endif
    return {31'b0, b};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input bit b,
                      input int p, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.is_busy = b; e.port = p; e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_model(input string tag);
    for (int p = 0; p < NR; p++) begin
      push(tag, 1'b0, p, model_rd(p));
      push(tag, 1'b1, p, model_busy(p));
    end
  endtask

  // Settle, then compare every queued expectation to the outputs.
  task automatic drain();
    exp_t        e;
    logic [31:0] act;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_busy) act = {31'b0, busy[e.port]};
      else           act = rd[e.port*W +: W];
      check(e.tag, act, e.val);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle();
    wen = '0; wa = '0; wd = '0;
    set_en = 1'b0; set_addr = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ra = '0;
    nxt();
    ra[0 +: AW] = 5'd5; ra[AW +: AW] = 5'd6;
    push("rst_rd0", 0, 0, 0); push("rst_rd1", 0, 1, 0);
    push("rst_bz0", 1, 0, 0); push("rst_bz1", 1, 1, 0);
    drain();
    nxt();
    rst = 1'b0;
    nxt();

    // 1: write x5, set x6 pending, then async reset
    wen = 2'b01; wa[0 +: AW] = 5'd5; wd[0 +: W] = 32'hDEADBEEF;
    set_en = 1'b1; set_addr = 5'd6;
    drain(); nxt(); idle();
    push("t1_wr", 0, 0, 32'hDEADBEEF);
    push("t1_set", 1, 1, 1);
    drain();
    #2 rst = 1'b1;
    push("t1_rst_rd", 0, 0, 0);
    push("t1_rst_bz0", 1, 0, 0);
    push("t1_rst_bz1", 1, 1, 0);
    drain();
    nxt(); rst = 1'b0; nxt();

    // 2: zero register ignores write and set
    wen = 2'b01; wa[0 +: AW] = 5'd0; wd[0 +: W] = 32'hFFFFFFFF;
    set_en = 1'b1; set_addr = 5'd0;
    ra = '0;
    push("t2_pre_rd", 0, 0, 0);
    drain(); nxt(); idle();
    push("t2_rd", 0, 0, 0); push("t2_bz", 1, 0, 0);
    drain();

    // 3: write port conflict, port 1 wins
    wen = 2'b11;
    wa[0 +: AW] = 5'd7; wd[0 +: W] = 32'h11;
    wa[AW +: AW] = 5'd7; wd[W +: W] = 32'h22;
    drain(); nxt(); idle();
    ra[0 +: AW] = 5'd7;
    push("t3_conf", 0, 0, 32'h22);
    drain();

    // 4: bypass
    wen = 2'b01; wa[0 +: AW] = 5'd3; wd[0 +: W] = 32'h5;
    drain(); nxt(); idle();
    wen = 2'b01; wa[0 +: AW] = 5'd3; wd[0 +: W] = 32'hA;
    ra[0 +: AW] = 5'd3;
`ifdef REGFILE_BYPASS_EN
    push("t4_same", 0, 0, 32'hA);
`else
    push("t4_same", 0, 0, 32'h5);
`endif
    drain(); nxt(); idle();
    push("t4_next", 0, 0, 32'hA);
    drain();

    // 5: scoreboard on x9
    set_en = 1'b1; set_addr = 5'd9; ra[0 +: AW] = 5'd9;
    push("t5_pre", 1, 0, 0);
    drain(); nxt(); idle();
    push("t5_n", 1, 0, 1);
    drain(); nxt();
    push("t5_hold", 1, 0, 1);
    drain(); nxt();
    wen = 2'b10; wa[AW +: AW] = 5'd9; wd[W +: W] = 32'h99;
`ifdef REGFILE_BYPASS_EN
    push("t5_m", 1, 0, 0);
`else
    push("t5_m", 1, 0, 1);
`endif
    drain(); nxt(); idle();
    push("t5_after", 1, 0, 0);
    push("t5_rd", 0, 0, 32'h99);
    drain();

    // 6: set/clear collision on x4
    set_en = 1'b1; set_addr = 5'd4;
    drain(); nxt(); idle();
    wen = 2'b01; wa[0 +: AW] = 5'd4; wd[0 +: W] = 32'h77;
    set_en = 1'b1; set_addr = 5'd4;
    ra[0 +: AW] = 5'd4; ra[AW +: AW] = 5'd4;
    push("t6_same_bz", 1, 0, 1);
    drain(); nxt(); idle();
    push("t6_rd", 0, 0, 32'h77);
    push("t6_bz0", 1, 0, 1);
    push("t6_bz1", 1, 1, 1);
    drain();

    // Out-of-range address
    wen = 2'b01; wa[0 +: AW] = 5'd25; wd[0 +: W] = 32'h1234;
    set_en = 1'b1; set_addr = 5'd25;
    ra[0 +: AW] = 5'd25;
    push("oor_pre", 0, 0, 0);
    drain(); nxt(); idle();
    push("oor_rd", 0, 0, 0); push("oor_bz", 1, 0, 0);
    drain();

    // Randomized traffic checked against the model
    for (int c = 0; c < 400; c++) begin
      wen = 2'($urandom_range(0, 3));
      wa[0 +: AW]  = 5'($urandom_range(0, 12));
      wa[AW +: AW] = 5'($urandom_range(0, 12));
      wd = {$urandom, $urandom};
      set_en   = 1'($urandom_range(0, 1));
      set_addr = 5'($urandom_range(0, 12));
      ra[0 +: AW]  = 5'($urandom_range(0, 12));
      ra[AW +: AW] = 5'($urandom_range(0, 31));
      push_model("rand");
      drain();
      nxt();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
